up_down_counter: RTL and testbench

- Loadable 16-bit synchronous up/down counter; a general-purpose counting primitive for control and datapath blocks.
- Per cycle it does one of: reset, parallel load, count up, count down, or hold.
- data_out is fully registered; control inputs are sampled on the rising edge of clk.
- Wrap-around carry/borrow pulses (wrap_up, wrap_dn) let counters be chained.

---
 rtl/up_down_counter_pkg.sv | 13 +
 rtl/up_down_counter_next.sv | 50 +++++
 rtl/up_down_counter.sv | 62 ++++++
 tb/tb_up_down_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared types for the loadable up/down counter: default width and the per-cycle operation code.
package up_down_counter_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_e;

endpackage

// File: rtl/up_down_counter_next.sv
// Next-state arithmetic for the counter; modulo wrap, or saturation when UP_DOWN_COUNTER_SATURATE_EN is defined.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle.
module up_down_counter_next
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic [WIDTH-1:0] cur,
    input  cnt_op_e          op,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_up_nxt,
    output logic             wrap_dn_nxt
);

    logic at_max;
    logic at_min;

    assign at_max = (cur == {WIDTH{1'b1}});
    assign at_min = (cur == '0);

    always_comb begin
        nxt         = cur;
        wrap_up_nxt = 1'b0;
        wrap_dn_nxt = 1'b0;
        case (op)
            OP_UP: begin
                wrap_up_nxt = at_max;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                nxt = at_max ? cur : cur + WIDTH'(1);
`else
                nxt = cur + WIDTH'(1);
`endif
            end
            OP_DOWN: begin
                wrap_dn_nxt = at_min;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                nxt = at_min ? cur : cur - WIDTH'(1);
`else
                nxt = cur - WIDTH'(1);
`endif
            end
            // Load value is muxed in by the top; hold and load leave the count untouched here.
            default: begin
                nxt = cur;
            end
        endcase
    end

endmodule

// File: rtl/up_down_counter.sv
// Loadable up/down counter with carry/borrow pulses; UP_DOWN_COUNTER_SATURATE_EN selects saturating counting.
// Latency: one cycle from sampled controls to data_out/wrap_up/wrap_dn, all registered.
// Backpressure: none; an operation is accepted on every rising clock edge.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int               WIDTH   = CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_cnt,
    input  logic             updn_cnt,
    input  logic             count_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap_up,
    output logic             wrap_dn
);

    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_up_nxt;
    logic             wrap_dn_nxt;

    // Load outranks counting; direction only matters when counting is enabled.
    always_comb begin
        op = OP_HOLD;
        if (ld_cnt) begin
            op = OP_LOAD;
        end else if (count_enb) begin
            op = updn_cnt ? OP_UP : OP_DOWN;
        end
    end

    up_down_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .cur         (data_out),
        .op          (op),
        .nxt         (cnt_nxt),
        .wrap_up_nxt (wrap_up_nxt),
        .wrap_dn_nxt (wrap_dn_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            data_out <= RST_VAL;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
        end else if (op == OP_LOAD) begin
            data_out <= data_in;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
        end else begin
            data_out <= cnt_nxt;
            wrap_up  <= wrap_up_nxt;
            wrap_dn  <= wrap_dn_nxt;
        end
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: directed plan sequences followed by random traffic against an arithmetic model.
module tb_up_down_counter;
    import up_down_counter_pkg::*;

    localparam int W    = 16;
    localparam int MODV = 1 << W;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] val;
        logic         wu;
        logic         wd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         ld_cnt = 1'b0;
    logic         updn_cnt = 1'b0;
    logic         count_enb = 1'b0;
    logic [W-1:0] data_out;
    logic         wrap_up;
    logic         wrap_dn;

    exp_t exp_q[$];
    int   model = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   op_seen[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    up_down_counter dut (
        .clk       (clk),
        .rst_      (rst_),
        .data_in   (data_in),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_out  (data_out),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn)
    );

    // Drive one cycle of controls at the falling edge and queue the model's view of the next edge.
    task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                        input logic e, input logic u);
        exp_t x;
        int   v;
        @(negedge clk);
        rst_ = r; ld_cnt = l; data_in = d; count_enb = e; updn_cnt = u;
        x.wu = 1'b0;
        x.wd = 1'b0;
        if (r) begin
            model = 0;
        end else if (l) begin
            model = int'(d);
            op_seen[OP_LOAD]++;
        end else if (e && u) begin
            op_seen[OP_UP]++;
            v = model + 1;
            if (v >= MODV) begin
                x.wu  = 1'b1;
                model = SAT ? MODV - 1 : v - MODV;
            end else begin
                model = v;
            end
        end else if (e) begin
            op_seen[OP_DOWN]++;
            v = model - 1;
            if (v < 0) begin
                x.wd  = 1'b1;
                model = SAT ? 0 : v + MODV;
            end else begin
                model = v;
            end
        end else begin
            op_seen[OP_HOLD]++;
        end
        x.val = model[W-1:0];
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Direct look at the output produced by the edge right after the most recent step.
    task automatic peek(input string name, input logic [W-1:0] req);
        @(posedge clk);
        #3;
        chk(name, data_out, req);
    endtask

    // Monitor: one registered result per edge; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out", data_out, e.val);
                chk("wrap_up", W'(wrap_up), W'(e.wu));
                chk("wrap_dn", W'(wrap_dn), W'(e.wd));
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        int           sel;

        // Reset beats load.
        step(1, 1, 16'h1234, 0, 0);
        step(1, 1, 16'h1234, 0, 0);
        peek("reset_val", 16'h0000);

        // Load beats count.
        step(0, 1, 16'hA5A5, 1, 1);
        peek("load_over_cnt", 16'hA5A5);

        // Count up then hold.
        step(0, 1, 16'h0010, 0, 0);
        repeat (5) step(0, 0, '0, 1, 1);
        peek("count_up_5", 16'h0015);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        peek("hold", 16'h0015);

        // Count down through zero.
        step(0, 1, 16'h0003, 0, 0);
        repeat (5) step(0, 0, '0, 1, 0);
        peek("count_dn_5", SAT ? 16'h0000 : 16'hFFFE);

        // Count up through all-ones.
        step(0, 1, 16'hFFFE, 0, 0);
        repeat (3) step(0, 0, '0, 1, 1);
        peek("count_up_wrap", SAT ? 16'hFFFF : 16'h0001);

        // Direction flips, then a mid-count reset.
        step(0, 1, 16'h0100, 0, 0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        peek("dir_flip", 16'h00FF);
        step(1, 0, '0, 1, 1);
        peek("mid_reset", 16'h0000);
        step(0, 0, '0, 1, 1);
        peek("resume", 16'h0001);

        // Random traffic, biased towards the limits so wraps actually occur.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       d = 16'h0000;
                1:       d = 16'h0001;
                2:       d = 16'hFFFE;
                3:       d = 16'hFFFF;
                default: d = W'($urandom);
            endcase
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), d,
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
        end

        step(0, 0, '0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("op mix: hold=%0d load=%0d up=%0d down=%0d",
                 op_seen[OP_HOLD], op_seen[OP_LOAD], op_seen[OP_UP], op_seen[OP_DOWN]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
